// File: rtl/sdx_kernel_addwm_example_wm_write_master.sv
// rtl/sdx_kernel_addwm_example_wm_write_master.sv - AXI4 write master draining a kernel stream into memory bursts
module sdx_kernel_addwm_example_wm_write_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_BURST_LEN        = 64,
  parameter int C_MAX_OUTSTANDING  = 32
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            ctrl_start,
  output logic                            ctrl_done,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0]    ctrl_xfer_size_in_bytes,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_axis_tdata,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                      m_axi_awlen,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wlast,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready
);

  localparam int XW          = C_XFER_SIZE_WIDTH;
  localparam int AW          = C_M_AXI_ADDR_WIDTH;
  localparam int BYTES       = C_M_AXI_DATA_WIDTH / 8;
  localparam int BYTES_SHIFT = $clog2(BYTES);
  localparam int BL_SHIFT    = $clog2(C_BURST_LEN);
  localparam int BURST_SHIFT = BYTES_SHIFT + BL_SHIFT;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   base_q, base_d;
  logic [XW-1:0]   beats_q, beats_d;
  logic [XW-1:0]   bursts_q, bursts_d;
  logic [XW-1:0]   aw_cnt_q, aw_cnt_d;
  logic [XW-1:0]   b_cnt_q, b_cnt_d;
  logic [XW-1:0]   w_burst_q, w_burst_d;
  logic [7:0]      w_beat_q, w_beat_d;
  logic            awvalid_q, awvalid_d;
  logic [AW-1:0]   awaddr_q, awaddr_d;
  logic [7:0]      awlen_q, awlen_d;

  // Start-time sizing is done one bit wider so the round-up never wraps.
  logic [XW:0]     start_round;
  logic [XW-1:0]   start_beats;
  logic [XW:0]     start_burst_round;
  logic [XW-1:0]   start_bursts;
  logic [XW-1:0]   rem_beats;
  logic [7:0]      last_len_m1;
  logic [7:0]      w_len_m1;
  logic            w_enable;
  logic            aw_hs;
  logic            w_hs;
  logic            b_take;
  logic            unused_tlast;

  assign start_round       = {1'b0, ctrl_xfer_size_in_bytes} + (C_XFER_SIZE_WIDTH+1)'(BYTES - 1);
  assign start_beats       = XW'(start_round >> BYTES_SHIFT);
  assign start_burst_round = {1'b0, start_beats} + (C_XFER_SIZE_WIDTH+1)'(C_BURST_LEN - 1);
  assign start_bursts      = XW'(start_burst_round >> BL_SHIFT);

  // Final burst carries the remainder, or a full burst when the beats divide evenly.
  assign rem_beats   = beats_q & XW'(C_BURST_LEN - 1);
  assign last_len_m1 = (rem_beats == '0) ? 8'(C_BURST_LEN - 1) : 8'(rem_beats - 1'b1);
  assign w_len_m1    = (w_burst_q == bursts_q - 1'b1) ? last_len_m1 : 8'(C_BURST_LEN - 1);

  // W data may only flow for bursts whose address has already been accepted.
  assign w_enable      = (state_q == S_BUSY) && (w_burst_q < aw_cnt_q);
  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wvalid  = s_axis_tvalid & w_enable;
  assign s_axis_tready = m_axi_wready & w_enable;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = w_enable && (w_beat_q == w_len_m1);
  assign m_axi_bready  = (state_q == S_BUSY);
  assign ctrl_done     = (state_q == S_DONE);
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign unused_tlast  = s_axis_tlast;

  assign aw_hs  = awvalid_q & m_axi_awready;
  assign w_hs   = m_axi_wvalid & m_axi_wready;
  // A stray response with nothing outstanding is not counted.
  assign b_take = m_axi_bvalid & m_axi_bready & (b_cnt_q < aw_cnt_q);

  // Next-state: control FSM, burst bookkeeping and AW request generation.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    beats_d   = beats_q;
    bursts_d  = bursts_q;
    aw_cnt_d  = aw_cnt_q;
    b_cnt_d   = b_cnt_q;
    w_burst_d = w_burst_q;
    w_beat_d  = w_beat_q;
    awvalid_d = awvalid_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    case (state_q)
      S_IDLE: begin
        if (ctrl_start) begin
          base_d    = ctrl_addr_offset;
          beats_d   = start_beats;
          bursts_d  = start_bursts;
          aw_cnt_d  = '0;
          b_cnt_d   = '0;
          w_burst_d = '0;
          w_beat_d  = '0;
          state_d   = (start_beats == '0) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (aw_hs) aw_cnt_d = aw_cnt_q + 1'b1;
        if (b_take) b_cnt_d = b_cnt_q + 1'b1;
        if (w_hs) begin
          if (m_axi_wlast) begin
            w_beat_d  = '0;
            w_burst_d = w_burst_q + 1'b1;
          end else begin
            w_beat_d = w_beat_q + 8'd1;
          end
        end
        // A pending request holds its payload until accepted; otherwise look ahead using next counts.
        if (!awvalid_q || m_axi_awready) begin
          awvalid_d = (aw_cnt_d < bursts_q) && ((aw_cnt_d - b_cnt_d) < XW'(C_MAX_OUTSTANDING));
          if (awvalid_d) begin
            awaddr_d = base_q + (AW'(aw_cnt_d) << BURST_SHIFT);
            awlen_d  = (aw_cnt_d == bursts_q - 1'b1) ? last_len_m1 : 8'(C_BURST_LEN - 1);
          end
        end
        if ((b_cnt_q == bursts_q) && (w_burst_q == bursts_q)) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers, cleared asynchronously.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      beats_q   <= '0;
      bursts_q  <= '0;
      aw_cnt_q  <= '0;
      b_cnt_q   <= '0;
      w_burst_q <= '0;
      w_beat_q  <= '0;
      awvalid_q <= 1'b0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      beats_q   <= beats_d;
      bursts_q  <= bursts_d;
      aw_cnt_q  <= aw_cnt_d;
      b_cnt_q   <= b_cnt_d;
      w_burst_q <= w_burst_d;
      w_beat_q  <= w_beat_d;
      awvalid_q <= awvalid_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
    end
  end

endmodule

// File: tb/tb_sdx_kernel_addwm_example_wm_write_master.sv
// tb/tb_sdx_kernel_addwm_example_wm_write_master.sv - directed self-checking bench for the write master
module tb_sdx_kernel_addwm_example_wm_write_master;
  localparam int AW = 64;
  localparam int DW = 512;
  localparam int XW = 32;

  logic            aclk = 1'b0;
  logic            areset;
  logic            ctrl_start;
  logic            ctrl_done;
  logic [AW-1:0]   ctrl_addr_offset;
  logic [XW-1:0]   ctrl_xfer_size_in_bytes;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic            s_axis_tlast;
  logic [DW-1:0]   s_axis_tdata;
  logic            m_axi_awvalid;
  logic            m_axi_awready;
  logic [AW-1:0]   m_axi_awaddr;
  logic [7:0]      m_axi_awlen;
  logic            m_axi_wvalid;
  logic            m_axi_wready;
  logic [DW-1:0]   m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic            m_axi_wlast;
  logic            m_axi_bvalid;
  logic            m_axi_bready;

  always #5 aclk = ~aclk;

  sdx_kernel_addwm_example_wm_write_master dut (
    .aclk(aclk), .areset(areset), .ctrl_start(ctrl_start), .ctrl_done(ctrl_done),
    .ctrl_addr_offset(ctrl_addr_offset), .ctrl_xfer_size_in_bytes(ctrl_xfer_size_in_bytes),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_axis_tdata(s_axis_tdata), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  int checks = 0;
  int failures = 0;

  // Slave/source behaviour: 0 = always ready/valid, 1 = random. b_mode: 0 const 1, 1 responder, 2 random responder, 3 held low.
  bit start_pulse;
  int aw_mode, w_mode, t_mode, b_mode;

  logic [AW-1:0] aw_addr_log[$];
  logic [7:0]    aw_len_log[$];
  int            wlast_log[$];
  int cycle, src_idx, w_idx, aw_hs, w_bursts, b_hs, pending_b, done_cnt, first_done, start_cycle;
  int b_at_done, valid_cycles, wdata_err, wstrb_err, lead_err, aw_unstable;
  bit            aw_pend;
  logic [AW-1:0] aw_pend_addr;
  logic [7:0]    aw_pend_len;

  function automatic logic [DW-1:0] mk_data(input int idx);
    logic [31:0] w;
    w = 32'h5A5A_0000 ^ 32'(idx);
    return {16{w}};
  endfunction

  task automatic clear_logs();
    aw_addr_log.delete(); aw_len_log.delete(); wlast_log.delete();
    cycle = 0; src_idx = 0; w_idx = 0; aw_hs = 0; w_bursts = 0; b_hs = 0; pending_b = 0;
    done_cnt = 0; first_done = -1; start_cycle = -1; b_at_done = -1; valid_cycles = 0;
    wdata_err = 0; wstrb_err = 0; lead_err = 0; aw_unstable = 0; aw_pend = 0;
  endtask

  // One clock: drive inputs just after the edge, then observe the settled handshakes.
  task automatic step();
    @(posedge aclk);
    #1;
    ctrl_start = start_pulse;
    if (start_pulse) start_cycle = cycle;
    start_pulse = 0;
    m_axi_awready = (aw_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    m_axi_wready  = (w_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    s_axis_tvalid = (t_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    s_axis_tlast  = 1'($urandom_range(0, 1));
    s_axis_tdata  = mk_data(src_idx);
    case (b_mode)
      0: m_axi_bvalid = 1'b1;
      1: m_axi_bvalid = (pending_b > 0);
      2: m_axi_bvalid = (pending_b > 0) && ($urandom_range(0, 1) == 1);
      default: m_axi_bvalid = 1'b0;
    endcase
    #1;
    if (m_axi_wvalid && m_axi_wready) begin
      if (m_axi_wdata !== mk_data(w_idx)) wdata_err++;
      if (m_axi_wstrb !== '1) wstrb_err++;
      if (w_bursts >= aw_hs) lead_err++;
      w_idx++;
      if (m_axi_wlast) begin
        wlast_log.push_back(w_idx);
        w_bursts++;
        pending_b++;
      end
    end
    if (aw_pend && (!m_axi_awvalid || m_axi_awaddr !== aw_pend_addr || m_axi_awlen !== aw_pend_len)) aw_unstable++;
    if (m_axi_awvalid && m_axi_awready) begin
      aw_addr_log.push_back(m_axi_awaddr);
      aw_len_log.push_back(m_axi_awlen);
      aw_hs++;
    end
    aw_pend = m_axi_awvalid && !m_axi_awready && !areset;
    aw_pend_addr = m_axi_awaddr;
    aw_pend_len = m_axi_awlen;
    if (s_axis_tvalid && s_axis_tready) src_idx++;
    if (m_axi_bvalid && m_axi_bready) begin
      b_hs++;
      if (pending_b > 0) pending_b--;
    end
    if (ctrl_done) begin
      if (done_cnt == 0) begin
        first_done = cycle;
        b_at_done = b_hs;
      end
      done_cnt++;
    end
    if (m_axi_awvalid || m_axi_wvalid) valid_cycles++;
    cycle++;
  endtask

  task automatic run_until_done(input int bound, output bit timed_out);
    int n;
    n = 0;
    while (done_cnt == 0 && n < bound) begin
      step();
      n++;
    end
    timed_out = (done_cnt == 0);
    repeat (3) step();
  endtask

  task automatic test_reset();
    logic [4:0] ctl;
    clear_logs();
    areset = 1'b1; ctrl_start = 1'b1; s_axis_tvalid = 1'b1; m_axi_wready = 1'b1;
    m_axi_awready = 1'b1; m_axi_bvalid = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    ctl = {m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axis_tready, ctrl_done};
    checks++; if (ctl !== 5'b0) begin failures++; $display("FAIL reset_ctrl_outputs actual=%b expected=00000", ctl); end
    checks++; if (m_axi_awaddr !== '0) begin failures++; $display("FAIL reset_awaddr actual=%h expected=0", m_axi_awaddr); end
    checks++; if (m_axi_awlen !== 8'd0) begin failures++; $display("FAIL reset_awlen actual=%0d expected=0", m_axi_awlen); end
    areset = 1'b0; ctrl_start = 1'b0;
    repeat (4) step();
    checks++; if (valid_cycles !== 0 || done_cnt !== 0) begin failures++; $display("FAIL idle_quiet actual=%0d/%0d expected=0/0", valid_cycles, done_cnt); end
  endtask

  task automatic test_single();
    bit to;
    clear_logs();
    aw_mode = 0; w_mode = 0; t_mode = 0; b_mode = 0;
    ctrl_addr_offset = 64'h1000; ctrl_xfer_size_in_bytes = 32'd64; start_pulse = 1;
    run_until_done(200, to);
    checks++; if (to) begin failures++; $display("FAIL single_timeout actual=no_done expected=done"); end
    checks++; if (aw_hs !== 1) begin failures++; $display("FAIL single_aw_count actual=%0d expected=1", aw_hs); end
    checks++; if (aw_addr_log.size() < 1 || aw_addr_log[0] !== 64'h1000 || aw_len_log[0] !== 8'd0) begin failures++; $display("FAIL single_aw_payload actual=%0d entries expected=addr 1000 len 0", aw_addr_log.size()); end
    checks++; if (w_idx !== 1 || wlast_log.size() != 1 || wlast_log[0] !== 1) begin failures++; $display("FAIL single_w_beats actual=%0d beats expected=1 beat with wlast", w_idx); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL single_done_pulse actual=%0d expected=1", done_cnt); end
    checks++; if (wdata_err !== 0 || wstrb_err !== 0) begin failures++; $display("FAIL single_wdata actual=%0d/%0d errors expected=0/0", wdata_err, wstrb_err); end
  endtask

  task automatic test_multi();
    bit to;
    logic [AW-1:0] ea [3];
    logic [7:0]    el [3];
    int            ew [3];
    ea[0] = 64'h0; ea[1] = 64'h1000; ea[2] = 64'h2000;
    el[0] = 8'd63; el[1] = 8'd63; el[2] = 8'd0;
    ew[0] = 64; ew[1] = 128; ew[2] = 129;
    clear_logs();
    aw_mode = 0; w_mode = 0; t_mode = 0; b_mode = 1;
    ctrl_addr_offset = 64'h0; ctrl_xfer_size_in_bytes = 32'd8256; start_pulse = 1;
    repeat (10) step();
    ctrl_addr_offset = 64'h9000; ctrl_xfer_size_in_bytes = 32'd640; start_pulse = 1;
    run_until_done(1000, to);
    checks++; if (to) begin failures++; $display("FAIL multi_timeout actual=no_done expected=done"); end
    checks++; if (aw_hs !== 3) begin failures++; $display("FAIL multi_aw_count actual=%0d expected=3", aw_hs); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (aw_addr_log.size() <= i || aw_addr_log[i] !== ea[i] || aw_len_log[i] !== el[i]) begin failures++; $display("FAIL multi_aw_%0d actual=size %0d expected=addr %h len %0d", i, aw_addr_log.size(), ea[i], el[i]); end
      checks++; if (wlast_log.size() <= i || wlast_log[i] !== ew[i]) begin failures++; $display("FAIL multi_wlast_%0d actual=size %0d expected=beat %0d", i, wlast_log.size(), ew[i]); end
    end
    checks++; if (w_idx !== 129 || wdata_err !== 0) begin failures++; $display("FAIL multi_w_total actual=%0d beats %0d errs expected=129 beats 0 errs", w_idx, wdata_err); end
    checks++; if (done_cnt !== 1 || b_at_done !== 3) begin failures++; $display("FAIL multi_done actual=%0d pulses at %0d B expected=1 pulse at 3 B", done_cnt, b_at_done); end
  endtask

  task automatic test_zero();
    bit to;
    clear_logs();
    aw_mode = 0; w_mode = 0; t_mode = 0; b_mode = 1;
    ctrl_addr_offset = 64'h4000; ctrl_xfer_size_in_bytes = 32'd0; start_pulse = 1;
    run_until_done(20, to);
    checks++; if (to || first_done - start_cycle !== 1) begin failures++; $display("FAIL zero_done_latency actual=%0d expected=1", first_done - start_cycle); end
    checks++; if (valid_cycles !== 0 || aw_hs !== 0) begin failures++; $display("FAIL zero_no_valid actual=%0d valid cycles expected=0", valid_cycles); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL zero_done_pulse actual=%0d expected=1", done_cnt); end
  endtask

  task automatic test_outstanding();
    bit to;
    clear_logs();
    aw_mode = 0; w_mode = 0; t_mode = 0; b_mode = 3;
    ctrl_addr_offset = 64'h0; ctrl_xfer_size_in_bytes = 32'd163840; start_pulse = 1;
    repeat (2300) step();
    checks++; if (aw_hs !== 32) begin failures++; $display("FAIL outst_aw_cap actual=%0d expected=32", aw_hs); end
    checks++; if (m_axi_awvalid !== 1'b0 || done_cnt !== 0) begin failures++; $display("FAIL outst_stalled actual=awvalid %b done %0d expected=0 0", m_axi_awvalid, done_cnt); end
    b_mode = 1;
    run_until_done(3000, to);
    checks++; if (to) begin failures++; $display("FAIL outst_timeout actual=no_done expected=done"); end
    checks++; if (aw_hs !== 40 || b_at_done !== 40) begin failures++; $display("FAIL outst_totals actual=%0d AW %0d B expected=40 40", aw_hs, b_at_done); end
    checks++; if (aw_addr_log.size() != 40 || aw_addr_log[39] !== 64'h27000 || aw_len_log[39] !== 8'd63) begin failures++; $display("FAIL outst_last_aw actual=size %0d expected=addr 27000 len 63", aw_addr_log.size()); end
    checks++; if (w_idx !== 2560 || wdata_err !== 0 || done_cnt !== 1) begin failures++; $display("FAIL outst_w actual=%0d beats %0d errs %0d done expected=2560 0 1", w_idx, wdata_err, done_cnt); end
  endtask

  task automatic test_backpressure();
    bit to;
    clear_logs();
    aw_mode = 1; w_mode = 1; t_mode = 1; b_mode = 2;
    ctrl_addr_offset = 64'h7000; ctrl_xfer_size_in_bytes = 32'd9000; start_pulse = 1;
    run_until_done(5000, to);
    checks++; if (to) begin failures++; $display("FAIL bp_timeout actual=no_done expected=done"); end
    checks++; if (wdata_err !== 0 || w_idx !== 141 || src_idx !== 141) begin failures++; $display("FAIL bp_data actual=%0d errs %0d/%0d beats expected=0 141/141", wdata_err, w_idx, src_idx); end
    checks++; if (lead_err !== 0) begin failures++; $display("FAIL bp_w_before_aw actual=%0d expected=0", lead_err); end
    checks++; if (aw_unstable !== 0) begin failures++; $display("FAIL bp_aw_stable actual=%0d expected=0", aw_unstable); end
    checks++; if (aw_hs !== 3 || aw_addr_log[2] !== 64'h9000 || aw_len_log[2] !== 8'd12 || aw_addr_log[1] !== 64'h8000) begin failures++; $display("FAIL bp_aw actual=%0d AW expected=3 AW last 9000/12", aw_hs); end
    checks++; if (wlast_log.size() != 3 || wlast_log[2] !== 141 || wlast_log[1] !== 128) begin failures++; $display("FAIL bp_wlast actual=size %0d expected=64,128,141", wlast_log.size()); end
    checks++; if (done_cnt !== 1 || b_at_done !== 3) begin failures++; $display("FAIL bp_done actual=%0d at %0d B expected=1 at 3", done_cnt, b_at_done); end
  endtask

  task automatic test_reset_mid();
    bit to;
    logic [4:0] ctl;
    clear_logs();
    aw_mode = 0; w_mode = 0; t_mode = 0; b_mode = 1;
    ctrl_addr_offset = 64'h0; ctrl_xfer_size_in_bytes = 32'd8256; start_pulse = 1;
    repeat (30) step();
    checks++; if (w_idx == 0) begin failures++; $display("FAIL rmid_in_progress actual=%0d beats expected=nonzero", w_idx); end
    @(posedge aclk);
    #3;
    areset = 1'b1;
    #1;
    ctl = {m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axis_tready, ctrl_done};
    checks++; if (ctl !== 5'b0 || m_axi_awaddr !== '0 || m_axi_awlen !== 8'd0) begin failures++; $display("FAIL rmid_outputs actual=%b addr %h len %0d expected=0", ctl, m_axi_awaddr, m_axi_awlen); end
    repeat (3) step();
    areset = 1'b0;
    repeat (3) step();
    checks++; if (done_cnt !== 0) begin failures++; $display("FAIL rmid_no_done actual=%0d expected=0", done_cnt); end
    clear_logs();
    ctrl_addr_offset = 64'h2000; ctrl_xfer_size_in_bytes = 32'd64; start_pulse = 1;
    run_until_done(200, to);
    checks++; if (to || done_cnt !== 1) begin failures++; $display("FAIL rmid_restart_done actual=%0d expected=1", done_cnt); end
    checks++; if (aw_hs !== 1 || aw_addr_log[0] !== 64'h2000 || aw_len_log[0] !== 8'd0) begin failures++; $display("FAIL rmid_restart_aw actual=%0d AW expected=1 at 2000 len 0", aw_hs); end
    checks++; if (w_idx !== 1 || wdata_err !== 0 || wlast_log.size() != 1) begin failures++; $display("FAIL rmid_restart_w actual=%0d beats %0d errs expected=1 0", w_idx, wdata_err); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    start_pulse = 0; aw_mode = 0; w_mode = 0; t_mode = 0; b_mode = 0;
    ctrl_addr_offset = '0; ctrl_xfer_size_in_bytes = '0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_zero();
    test_outstanding();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
